// File: rtl/data_mem_responder.sv
// Multi-cycle word-addressed data memory answering CPU loads/stores.
// Inserts WAIT_CYCLES wait states, stalls the CPU, and flags bad requests.
module data_mem_responder #(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        ready,
   output logic        err
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_nxt_s;
   logic [3:0]    cnt_r;
   logic          op_rd_r;
   logic          op_wr_r;
   logic [31:0]   addr_r;
   logic [31:0]   wdata_r;
   logic [31:0]   rdata_r;
   logic          err_r;
   logic [31:0]   mem_r [DEPTH];

   logic          req_s;
   logic          access_s;
   logic          conflict_s;
   logic          bad_addr_s;
   logic          mem_we_s;
   logic          stall_s;
   logic [AW-1:0] idx_s;

   // Request decode, access qualification and next-state logic.
   always_comb begin
      req_s       = mem_read | mem_write;
      access_s    = (state_r == ST_WAIT) && (cnt_r == 4'd0);
      conflict_s  = op_rd_r & op_wr_r;
      bad_addr_s  = (addr_r[1:0] != 2'b00) ||
                    ({2'b00, addr_r[31:2]} >= 32'(DEPTH));
      idx_s       = addr_r[AW+1:2];
      // A conflicting read+write is carried out as a store.
      mem_we_s    = access_s & op_wr_r & ~bad_addr_s;
      state_nxt_s = state_r;
      stall_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req_s) begin
               state_nxt_s = ST_WAIT;
               stall_s     = reset;
            end else begin
               state_nxt_s = ST_IDLE;
               stall_s     = 1'b0;
            end
         end
         ST_WAIT: begin
            stall_s = reset;
            if (cnt_r == 4'd0) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
            stall_s     = 1'b0;
         end
         default: begin
            state_nxt_s = ST_IDLE;
            stall_s     = 1'b0;
         end
      endcase
   end

   // FSM state, request capture, wait counter and completion outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
         op_rd_r <= 1'b0;
         op_wr_r <= 1'b0;
         addr_r  <= 32'd0;
         wdata_r <= 32'd0;
         rdata_r <= 32'd0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         case (state_r)
            ST_IDLE: begin
               if (req_s) begin
                  op_rd_r <= mem_read;
                  op_wr_r <= mem_write;
                  addr_r  <= addr;
                  wdata_r <= wdata;
                  cnt_r   <= 4'(WAIT_CYCLES - 1);
               end else begin
                  cnt_r   <= 4'd0;
               end
            end
            ST_WAIT: begin
               if (cnt_r != 4'd0) begin
                  cnt_r <= cnt_r - 4'd1;
               end else begin
                  rdata_r <= (!op_wr_r && !bad_addr_s) ? mem_r[idx_s] : 32'd0;
                  err_r   <= conflict_s | bad_addr_s;
               end
            end
            default: begin
               cnt_r <= 4'd0;
            end
         endcase
      end
   end

   // Storage array; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[idx_s] <= wdata_r;
      end
   end

   assign rdata = rdata_r;
   assign err   = err_r;
   assign ready = (state_r == ST_DONE);
   assign stall = stall_s;

endmodule
